// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared size codes, FSM states and the 64-bit data range macro
`ifndef RNG_64
`define RNG_64 63:0
`endif

package dmem_responder_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Byte-lane mask of an access of the given size, before the offset shift.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response handshake bundle between memory stage and responder
interface dmem_responder_if #(
  parameter int ADDR_W = 16
);
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_we;
  logic [ADDR_W-1:0] i_req_addr;
  logic [1:0]        i_req_size;
  logic [63:0]       i_req_wdata;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [63:0]       o_rsp_rdata;
  logic              o_rsp_err;

  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_size, i_req_wdata, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_size, i_req_wdata, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - combinational byte-lane steering for stores and zero-extending load alignment
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]       size,
  input  logic [2:0]       offset,
  input  logic [`RNG_64]   wdata,
  input  logic [`RNG_64]   rdata_raw,
  output logic [7:0]       strobe,
  output logic [`RNG_64]   wdata_sh,
  output logic [`RNG_64]   rdata_al,
  output logic             misaligned
);

  logic [7:0]     base_mask;
  logic [2:0]     align_mask;
  logic [`RNG_64] rd_sh;

  always_comb begin
    base_mask  = size_mask(size);
    case (size)
      SZ_B:    align_mask = 3'd0;
      SZ_H:    align_mask = 3'd1;
      SZ_W:    align_mask = 3'd3;
      default: align_mask = 3'd7;
    endcase
    // Lanes past byte 7 fall off the 8-bit strobe, which is the boundary truncation.
    strobe     = base_mask << offset;
    wdata_sh   = wdata << {offset, 3'b000};
    rd_sh      = rdata_raw >> {offset, 3'b000};
    misaligned = |(offset & align_mask);
    case (size)
      SZ_B:    rdata_al = {56'd0, rd_sh[7:0]};
      SZ_H:    rdata_al = {48'd0, rd_sh[15:0]};
      SZ_W:    rdata_al = {32'd0, rd_sh[31:0]};
      default: rdata_al = rd_sh;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with fixed wait states
// Optional: DMEM_ERR_RESP_EN turns misaligned accesses into error responses with no array write.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);

  localparam int         IDX_W   = ADDR_W - 3;
  localparam int         DEPTH   = 1 << IDX_W;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q;
  logic              ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [`RNG_64]    wdata_q;
  logic [`RNG_64]    rdata_q;
  logic              err_q;

  logic [`RNG_64]    mem [DEPTH];

  logic              accept;
  logic              do_access;
  logic              blocked;
  logic              misaligned;
  logic [7:0]        strobe;
  logic [`RNG_64]    wdata_sh;
  logic [`RNG_64]    rdata_al;
  logic [`RNG_64]    rdata_raw;
  logic [IDX_W-1:0]  idx;

  assign idx       = addr_q[ADDR_W-1:3];
  assign rdata_raw = mem[idx];
  assign accept    = (state_q == ST_IDLE) && ready_q && bus.i_req_valid;
  assign do_access = (state_q == ST_WAIT) && (cnt_q == 4'd0);

  dmem_lane_align u_align (
    .size       (size_q),
    .offset     (addr_q[2:0]),
    .wdata      (wdata_q),
    .rdata_raw  (rdata_raw),
    .strobe     (strobe),
    .wdata_sh   (wdata_sh),
    .rdata_al   (rdata_al),
    .misaligned (misaligned)
  );

`ifdef DMEM_ERR_RESP_EN
  assign blocked = misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign blocked           = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == 4'd0) state_d = ST_RESP;
      ST_RESP: if (bus.i_rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Ready is its own flop so it stays low through reset and has no input path.
  always_ff @(posedge clk) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= SZ_B;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= bus.i_req_we;
        addr_q  <= bus.i_req_addr;
        size_q  <= bus.i_req_size;
        wdata_q <= bus.i_req_wdata;
        cnt_q   <= WAIT_LD;
      end else if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (do_access) begin
        rdata_q <= (we_q || blocked) ? 64'd0 : rdata_al;
        err_q   <= blocked;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_access && we_q && !blocked) begin
      for (int b = 0; b < 8; b++) begin
        if (strobe[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  assign bus.o_req_ready = ready_q;
  assign bus.o_rsp_valid = (state_q == ST_RESP);
  assign bus.o_rsp_rdata = rdata_q;
  assign bus.o_rsp_err   = err_q;

endmodule
